// File: rtl/rsfq_pkg.sv
// Shared types and helpers for the RSFQ pulse deserializer.
// Holds the FSM encoding and bit-counter sizing.
package rsfq_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } rsfq_state_e;

    localparam int MIN_SYNC_STAGES = 2;

    // Width of a counter that must hold 0..w-1
    function automatic int cnt_width(input int w);
        return (w <= 2) ? 1 : $clog2(w);
    endfunction

endpackage

// File: rtl/rsfq_toggle_edge.sv
// Synchronizes a toggle-encoded line into the clk domain.
// Emits a one-clk event for every transition, either direction.
module rsfq_toggle_edge
    import rsfq_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic line_i,
    output logic event_o
);

    localparam int S = (SYNC_STAGES < MIN_SYNC_STAGES)
                     ? MIN_SYNC_STAGES : SYNC_STAGES;

    logic [S-1:0] sync_q;
    logic         prev_q;

    // Synchronizer chain plus one history flop for edge detection
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[S-2:0], line_i};
            prev_q <= sync_q[S-1];
        end
    end

    assign event_o = sync_q[S-1] ^ prev_q;

endmodule

// File: rtl/rsfq_pulse_deser.sv
// Rebuilds one bit per gate-clock cycle from toggle-encoded SFQ lines.
// Packs WIDTH bits into a word and hands it off on valid/ready.
module rsfq_pulse_deser
    import rsfq_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2,
    parameter bit MSB_FIRST   = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pulse_in,
    input  logic             frame_in,
    input  logic             err_clr,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             overflow,
    output logic             multi_pulse
);

    localparam int CW = cnt_width(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    logic pe, fe;

    rsfq_toggle_edge #(.SYNC_STAGES(SYNC_STAGES)) u_pulse (
        .clk     (clk),
        .rst     (rst),
        .line_i  (pulse_in),
        .event_o (pe)
    );

    rsfq_toggle_edge #(.SYNC_STAGES(SYNC_STAGES)) u_frame (
        .clk     (clk),
        .rst     (rst),
        .line_i  (frame_in),
        .event_o (fe)
    );

    rsfq_state_e      state_q, state_d;
    logic             win_q, win_d;
    logic [WIDTH-1:0] sh_q, sh_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             valid_q, valid_d;
    logic             ovf_q, ovf_d;
    logic             mp_q, mp_d;

    logic             bit_b;
    logic             ovf_ev, mp_ev;
    logic [WIDTH-1:0] sh_nxt;

    // State, window tracking, word assembly and handshake
    always_comb begin
        state_d = state_q;
        win_d   = win_q;
        sh_d    = sh_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        valid_d = valid_q;
        ovf_ev  = 1'b0;
        mp_ev   = 1'b0;
        bit_b   = win_q | pe;
        if (MSB_FIRST) begin
            sh_nxt = {sh_q[WIDTH-2:0], bit_b};
        end else begin
            sh_nxt = {bit_b, sh_q[WIDTH-1:1]};
        end

        if (valid_q && out_ready) begin
            valid_d = 1'b0;
        end

        unique case (state_q)
            IDLE: begin
                if (fe) begin
                    state_d = RUN;
                    win_d   = 1'b0;
                end
            end
            RUN: begin
                if (pe && win_q) begin
                    mp_ev = 1'b1;
                end
                if (fe) begin
                    win_d = 1'b0;
                    if (cnt_q == LAST) begin
                        cnt_d = '0;
                        sh_d  = '0;
                        if (valid_q && !out_ready) begin
                            ovf_ev = 1'b1;
                        end else begin
                            data_d  = sh_nxt;
                            valid_d = 1'b1;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                        sh_d  = sh_nxt;
                    end
                end else if (pe) begin
                    win_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        ovf_d = (ovf_q & ~err_clr) | ovf_ev;
        mp_d  = (mp_q & ~err_clr) | mp_ev;
    end

    // State and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            win_q   <= 1'b0;
            sh_q    <= '0;
            cnt_q   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ovf_q   <= 1'b0;
            mp_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            win_q   <= win_d;
            sh_q    <= sh_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ovf_q   <= ovf_d;
            mp_q    <= mp_d;
        end
    end

    assign out_data    = data_q;
    assign out_valid   = valid_q;
    assign overflow    = ovf_q;
    assign multi_pulse = mp_q;

endmodule

// File: tb/tb_rsfq_pulse_deser.sv
// Directed bench for rsfq_pulse_deser.
// Two instances: LSB-first and MSB-first share all stimulus.
module tb_rsfq_pulse_deser;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       pulse_in = 1'b0;
    logic       frame_in = 1'b0;
    logic       err_clr = 1'b0;
    logic       out_ready = 1'b1;
    logic [7:0] d0, d1;
    logic       v0, v1;
    logic       ovf0, ovf1;
    logic       mp0, mp1;

    int n_chk = 0;
    int n_err = 0;
    int xfer0 = 0;
    int xfer1 = 0;
    int vcnt0 = 0;
    logic [7:0] last0 = '0;
    logic [7:0] last1 = '0;

    always #5 clk = ~clk;

    rsfq_pulse_deser #(.WIDTH(8), .SYNC_STAGES(2), .MSB_FIRST(1'b0)) dut0 (
        .clk(clk), .rst(rst), .pulse_in(pulse_in), .frame_in(frame_in),
        .err_clr(err_clr), .out_data(d0), .out_valid(v0),
        .out_ready(out_ready), .overflow(ovf0), .multi_pulse(mp0)
    );

    rsfq_pulse_deser #(.WIDTH(8), .SYNC_STAGES(2), .MSB_FIRST(1'b1)) dut1 (
        .clk(clk), .rst(rst), .pulse_in(pulse_in), .frame_in(frame_in),
        .err_clr(err_clr), .out_data(d1), .out_valid(v1),
        .out_ready(out_ready), .overflow(ovf1), .multi_pulse(mp1)
    );

    // Record handshakes as seen at each active edge
    always @(posedge clk) begin
        if (!rst) begin
            if (v0) vcnt0 = vcnt0 + 1;
            if (v0 && out_ready) begin
                xfer0 = xfer0 + 1;
                last0 = d0;
            end
            if (v1 && out_ready) begin
                xfer1 = xfer1 + 1;
                last1 = d1;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic clr_mon();
        xfer0 = 0;
        xfer1 = 0;
        vcnt0 = 0;
        last0 = '0;
        last1 = '0;
    endtask

    // One gate cycle: optional pulse, then the closing frame edge
    task automatic send_bit(input logic b, input logic simul);
        if (b && simul) begin
            pulse_in = ~pulse_in;
            frame_in = ~frame_in;
            tick(3);
        end else begin
            if (b) pulse_in = ~pulse_in;
            tick(3);
            frame_in = ~frame_in;
            tick(3);
        end
    endtask

    task automatic send_word(input logic [7:0] w, input logic simul);
        for (int i = 0; i < 8; i++) send_bit(w[i], simul);
    endtask

    task automatic open_frame();
        frame_in = ~frame_in;
        tick(3);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        pulse_in = 1'b0;
        frame_in = 1'b0;
        tick(3);
        rst = 1'b0;
        tick(2);
    endtask

    initial begin
        tick(3);
        chk("rst_valid", 32'(v0), 32'h0);
        chk("rst_data", 32'(d0), 32'h0);
        chk("rst_ovf", 32'(ovf0), 32'h0);
        chk("rst_mp", 32'(mp0), 32'h0);
        rst = 1'b0;
        tick(2);

        // Basic capture: pulses in cycles 0,2,3,7
        clr_mon();
        open_frame();
        send_word(8'h8D, 1'b0);
        tick(4);
        chk("basic_xfer", 32'(xfer0), 32'd1);
        chk("basic_word", 32'(last0), 32'h8D);
        chk("basic_vcyc", 32'(vcnt0), 32'd1);
        chk("basic_vlow", 32'(v0), 32'h0);
        chk("basic_msbf", 32'(last1), 32'hB1);
        chk("basic_ovf", 32'(ovf0), 32'h0);
        chk("basic_mp", 32'(mp0), 32'h0);

        // Simultaneous pulse and frame edge
        clr_mon();
        send_word(8'h03, 1'b1);
        tick(4);
        chk("simul_xfer", 32'(xfer0), 32'd1);
        chk("simul_word", 32'(last0), 32'h03);
        chk("simul_mp", 32'(mp0), 32'h0);

        // Overflow with consumer stalled
        clr_mon();
        out_ready = 1'b0;
        send_word(8'hA5, 1'b0);
        tick(4);
        chk("ovf_v1", 32'(v0), 32'h1);
        chk("ovf_d1", 32'(d0), 32'hA5);
        chk("ovf_f1", 32'(ovf0), 32'h0);
        send_word(8'h3C, 1'b0);
        tick(4);
        chk("ovf_d2", 32'(d0), 32'hA5);
        chk("ovf_f2", 32'(ovf0), 32'h1);
        chk("ovf_v2", 32'(v0), 32'h1);
        out_ready = 1'b1;
        tick(2);
        chk("ovf_xfer", 32'(xfer0), 32'd1);
        chk("ovf_got", 32'(last0), 32'hA5);
        chk("ovf_vlow", 32'(v0), 32'h0);
        chk("ovf_hold", 32'(ovf0), 32'h1);
        err_clr = 1'b1;
        tick(1);
        err_clr = 1'b0;
        chk("ovf_clr", 32'(ovf0), 32'h0);

        // Multi-pulse in bit 0, then a clean word
        clr_mon();
        pulse_in = ~pulse_in;
        tick(3);
        pulse_in = ~pulse_in;
        tick(3);
        frame_in = ~frame_in;
        tick(3);
        for (int i = 1; i < 8; i++) send_bit(1'b0, 1'b0);
        tick(4);
        chk("mp_word", 32'(last0), 32'h01);
        chk("mp_flag", 32'(mp0), 32'h1);
        send_word(8'h5A, 1'b0);
        tick(4);
        chk("mp_next", 32'(last0), 32'h5A);
        chk("mp_xfer", 32'(xfer0), 32'd2);
        err_clr = 1'b1;
        tick(1);
        err_clr = 1'b0;
        chk("mp_clr", 32'(mp0), 32'h0);

        // Reset mid-word discards partial bits
        for (int i = 0; i < 5; i++) send_bit(1'b1, 1'b0);
        do_reset();
        clr_mon();
        chk("mid_vlow", 32'(v0), 32'h0);
        open_frame();
        send_word(8'hFF, 1'b0);
        tick(4);
        chk("mid_xfer", 32'(xfer0), 32'd1);
        chk("mid_word", 32'(last0), 32'hFF);

        // Pulses before the first frame edge are ignored
        do_reset();
        clr_mon();
        pulse_in = ~pulse_in;
        tick(3);
        pulse_in = ~pulse_in;
        tick(3);
        open_frame();
        send_word(8'h01, 1'b0);
        tick(4);
        chk("ord_x1", 32'(xfer1), 32'd1);
        chk("ord_msb", 32'(last1), 32'h80);
        chk("ord_lsb", 32'(last0), 32'h01);
        chk("ord_mp", 32'(mp1), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/rsfq_pulse_deser.md
Name: rsfq_pulse_deser

Overview:
- Downstream consumer of a clocked RSFQ gate such as the clocked OR2 cell. Each gate-clock cycle either produces one output pulse or none.
- Pulses arrive toggle-encoded: every transition of a line is one SFQ pulse.
- The block oversamples the gate output line and the gate clock line with a fast conventional clock. It rebuilds one logic bit per gate-clock cycle, packs WIDTH bits into a word and hands the word off through a valid/ready interface, with error flags.

Parameters:
- WIDTH, 8, bits per output word (2..32).
- SYNC_STAGES, 2, synchronizer flops on each asynchronous input (>=2).
- MSB_FIRST, 0, 0: first received bit lands in out_data[0]; 1: first received bit lands in out_data[WIDTH-1].

Ports:
- clk  in  1  sampling clock; must be faster than twice the toggle rate of either input.
- rst  in  1  asynchronous, active-high reset.
- pulse_in  in  1  toggle-encoded gate output (the "out" of the clocked gate).
- frame_in  in  1  toggle-encoded gate clock (the "clk" pulse line of the clocked gate).
- err_clr  in  1  synchronous clear for the sticky error flags.
- out_data  out  WIDTH  assembled word.
- out_valid  out  1  out_data is valid.
- out_ready  in  1  consumer accepts the word.
- overflow  out  1  sticky: a completed word was dropped.
- multi_pulse  out  1  sticky: more than one pulse arrived in one gate cycle.

Behaviour:
- **Reset values:** all synchronizer flops, edge-history flops, shift register, bit counter, window flag, out_data, out_valid, overflow and multi_pulse are 0. The FSM resets to IDLE. Deassertion of rst is taken at a clk edge.
- **Edge detection:** after SYNC_STAGES flops, an edge is signalled when sync output != the previous sample. This gives one event per transition, either direction.
- **IDLE state:**
  - pulse_in edges are ignored.
  - The first frame_in edge opens a window (win=0) and moves the FSM to RUN. No bit is shifted.
- **RUN state, per clk:**
  - A pulse edge with no frame edge: if win=1, set multi_pulse; then set win=1.
  - A frame edge closes the current window and shifts bit b = win (OR this cycle's pulse edge) into the shift register.
    - Shift direction follows MSB_FIRST.
    - bit_cnt increments, then win clears.
    - If this cycle also has a pulse edge and win was already 1, set multi_pulse.
  - **Simultaneous pulse and frame edge:** the pulse counts for the closing window, because the gate output lags its clock.
- **Word completion:** occurs when the frame edge shifts the WIDTH-th bit.
  - Next clk: out_data holds the word, out_valid=1, bit_cnt=0, and the shift register restarts. Latency is 1 clk after the completing frame-edge detection.
  - If out_valid=1 and out_ready=0 at completion, the new word is dropped, overflow is set, and out_data is unchanged.
  - If out_valid=1 and out_ready=1 in the completing cycle, the new word replaces the old one with no overflow.
- **Handshake:**
  - Transfer happens when out_valid and out_ready are both 1 at a clk edge. out_valid then falls unless a new word loads in the same edge.
  - out_data and out_valid hold while out_ready=0.
- **Error flags:**
  - err_clr clears both flags at the next clk.
  - If err_clr and a new error event occur in the same cycle, the flag ends set.
- **Reset mid-word:** the partial word is discarded and the FSM returns to IDLE. It resynchronizes on the next frame edge.
- **Wrap-around:** bit_cnt counts 0..WIDTH-1 and wraps to 0 on completion; it never reaches WIDTH.

Decomposition:
- **Shared package rsfq_pkg:**
  - FSM state enum (IDLE, RUN).
  - Function clog2-based width helper for bit_cnt.
  - Constant MIN_SYNC_STAGES=2.
- **One sub-module rsfq_toggle_edge:**
  - Parameterized SYNC_STAGES synchronizer plus toggle-to-event detector.
  - Instantiated twice, once for pulse_in and once for frame_in.

Test Plan:
- **Basic capture:** WIDTH=8, out_ready=1. Reset, one frame toggle to open, then 8 gate cycles with pulses in cycles 0,2,3,7 -> one word 8'h8D, out_valid high one clk, no flags.
- **Simultaneous events:** frame and pulse toggle in the same clk sample -> pulse lands in the closing bit. Sequence 1,1,0,0,0,0,0,0 -> 8'h03.
- **Overflow:** out_ready=0, stream two full words 8'hA5 then 8'h3C -> out_data stays 8'hA5, overflow=1. Raise out_ready -> handshake completes. err_clr -> overflow=0.
- **Multi-pulse:** two pulse toggles within one gate cycle -> bit=1 and multi_pulse=1. Following word is still correct.
- **Reset mid-word:** assert rst after 5 bits, release, send 8 bits 8'hFF after a re-opening frame edge -> out_data=8'hFF. Partial bits do not appear.
- **Ordering and idle:** MSB_FIRST=1, pulses before the first frame edge are ignored. Bits 1,0,0,0,0,0,0,0 -> 8'h80.
